// File: rtl/spi_master.sv
// SPI mode-0 master: shifts bytes out MSB-first on MOSI with a D/C sideband,
// samples MISO full-duplex on SCLK rising edges and returns each received byte.
module spi_master #(
  parameter int  CLK_DIV = 2,
  localparam int CNT_W   = $clog2(CLK_DIV + 1)
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       byte_vld_i,
  input  logic [7:0] byte_data_i,
  input  logic       byte_dc_i,
  input  logic       byte_last_i,
  output logic       byte_rdy_o,
  output logic       rx_vld_o,
  output logic [7:0] rx_data_o,
  output logic       busy_o,
  output logic       spi_sclk_o,
  output logic       spi_mosi_o,
  output logic       spi_cs_n_o,
  output logic       dc_o,
  input  logic       spi_miso_i
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    XFER  = 3'd2,
    WAIT  = 3'd3,
    HOLD  = 3'd4,
    GAP   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       bit_cnt_r;
  logic [7:0]       tx_sr_r;
  logic [7:0]       rx_sr_r;
  logic             last_r;
  logic             accept_s;
  logic             cnt_zero_s;

  // byte_rdy_o is itself registered, so an accept can only occur in IDLE or WAIT
  assign accept_s   = byte_vld_i & byte_rdy_o;
  assign cnt_zero_s = (cnt_r == {CNT_W{1'b0}});

  // Transfer sequencer: state, counters, shift registers and all SPI/handshake outputs
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r    <= IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      bit_cnt_r  <= 3'd0;
      tx_sr_r    <= 8'h00;
      rx_sr_r    <= 8'h00;
      last_r     <= 1'b0;
      byte_rdy_o <= 1'b0;
      rx_vld_o   <= 1'b0;
      rx_data_o  <= 8'h00;
      busy_o     <= 1'b0;
      spi_sclk_o <= 1'b0;
      spi_mosi_o <= 1'b0;
      spi_cs_n_o <= 1'b1;
      dc_o       <= 1'b0;
    end else begin
      rx_vld_o <= 1'b0;
      case (state_r)
        IDLE, WAIT: begin
          if (accept_s) begin
            tx_sr_r    <= byte_data_i;
            last_r     <= byte_last_i;
            dc_o       <= byte_dc_i;
            spi_mosi_o <= byte_data_i[7];
            spi_cs_n_o <= 1'b0;
            byte_rdy_o <= 1'b0;
            busy_o     <= 1'b1;
            cnt_r      <= CNT_RELOAD;
            state_r    <= SETUP;
          end else begin
            byte_rdy_o <= 1'b1;
            busy_o     <= (state_r == WAIT);
          end
        end
        SETUP: begin
          if (cnt_zero_s) begin
            spi_sclk_o <= 1'b1;
            rx_sr_r    <= {rx_sr_r[6:0], spi_miso_i};
            bit_cnt_r  <= 3'd0;
            cnt_r      <= CNT_RELOAD;
            state_r    <= XFER;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        XFER: begin
          if (!cnt_zero_s) begin
            cnt_r <= cnt_r - CNT_ONE;
          end else if (spi_sclk_o) begin
            // Falling edge: advance MOSI except after bit0, which is held
            spi_sclk_o <= 1'b0;
            cnt_r      <= CNT_RELOAD;
            if (bit_cnt_r != 3'd7) begin
              tx_sr_r    <= {tx_sr_r[6:0], 1'b0};
              spi_mosi_o <= tx_sr_r[6];
            end else begin
              tx_sr_r <= tx_sr_r;
            end
          end else if (bit_cnt_r == 3'd7) begin
            rx_vld_o  <= 1'b1;
            rx_data_o <= rx_sr_r;
            cnt_r     <= CNT_RELOAD;
            if (last_r) begin
              state_r <= HOLD;
            end else begin
              byte_rdy_o <= 1'b1;
              state_r    <= WAIT;
            end
          end else begin
            spi_sclk_o <= 1'b1;
            rx_sr_r    <= {rx_sr_r[6:0], spi_miso_i};
            bit_cnt_r  <= bit_cnt_r + 3'd1;
            cnt_r      <= CNT_RELOAD;
          end
        end
        HOLD: begin
          if (cnt_zero_s) begin
            spi_cs_n_o <= 1'b1;
            cnt_r      <= CNT_RELOAD;
            state_r    <= GAP;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        GAP: begin
          // Minimum CS-high time before the next frame may be accepted
          if (cnt_zero_s) begin
            byte_rdy_o <= 1'b1;
            busy_o     <= 1'b0;
            state_r    <= IDLE;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        default: begin
          byte_rdy_o <= 1'b0;
          busy_o     <= 1'b0;
          spi_sclk_o <= 1'b0;
          spi_cs_n_o <= 1'b1;
          state_r    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: table of single-byte frames at CLK_DIV = 2 plus
// hand-written burst, WAIT-stall, mid-transfer reset and CLK_DIV = 1 sequences.
module tb_spi_master;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // DUT a: CLK_DIV = 2, MISO from loopback or a small mode-0 slave model
  logic       a_vld, a_dc, a_last, a_rdy, a_rxv, a_busy, a_sclk, a_mosi, a_csn, a_dco, a_miso;
  logic [7:0] a_data, a_rxd;
  // DUT b: CLK_DIV = 1, MISO looped back
  logic       b_vld, b_dc, b_last, b_rdy, b_rxv, b_busy, b_sclk, b_mosi, b_csn, b_dco, b_miso;
  logic [7:0] b_data, b_rxd;

  spi_master #(.CLK_DIV(2)) u_dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .byte_vld_i(a_vld), .byte_data_i(a_data),
    .byte_dc_i(a_dc), .byte_last_i(a_last), .byte_rdy_o(a_rdy), .rx_vld_o(a_rxv),
    .rx_data_o(a_rxd), .busy_o(a_busy), .spi_sclk_o(a_sclk), .spi_mosi_o(a_mosi),
    .spi_cs_n_o(a_csn), .dc_o(a_dco), .spi_miso_i(a_miso)
  );

  spi_master #(.CLK_DIV(1)) u_dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .byte_vld_i(b_vld), .byte_data_i(b_data),
    .byte_dc_i(b_dc), .byte_last_i(b_last), .byte_rdy_o(b_rdy), .rx_vld_o(b_rxv),
    .rx_data_o(b_rxd), .busy_o(b_busy), .spi_sclk_o(b_sclk), .spi_mosi_o(b_mosi),
    .spi_cs_n_o(b_csn), .dc_o(b_dco), .spi_miso_i(b_miso)
  );

  assign b_miso = b_mosi;

  // Slave model: drives its byte MSB first, advancing on each SCLK falling edge
  logic       loop_a = 1'b1;
  logic [7:0] slv_byte = 8'h00;
  int         slv_idx = 0;
  always @(negedge a_sclk or posedge a_rxv or negedge rst_n)
    if (!rst_n || a_rxv) slv_idx = 0;
    else slv_idx = slv_idx + 1;
  assign a_miso = loop_a ? a_mosi : ((slv_idx < 8) ? slv_byte[3'(7 - slv_idx)] : 1'b0);

  // Free-running event counters; tests work on differences between snapshots
  int         acc_cnt = 0, rxv_cnt = 0, mosi0_cnt = 0, rise_cnt = 0, csn_rise = 0;
  logic [7:0] mosi_cap = 8'h00;
  always @(posedge clk) begin
    if (a_vld && a_rdy) acc_cnt <= acc_cnt + 1;
    if (a_rxv) rxv_cnt <= rxv_cnt + 1;
    if (!a_csn && !a_mosi) mosi0_cnt <= mosi0_cnt + 1;
  end
  always @(posedge a_sclk) begin
    mosi_cap <= {mosi_cap[6:0], a_mosi};
    rise_cnt <= rise_cnt + 1;
  end
  always @(posedge a_csn) csn_rise <= csn_rise + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_rdy_a();
    int t = 0;
    while (!a_rdy && t < 300) begin step(); t++; end
    check("a_rdy_wait", 32'(a_rdy), 32'd1);
  endtask

  // Offer one byte, check the accept cycle, return cycles from accept to rx_vld_o
  task automatic send_a(input logic [7:0] d, input logic dc, input logic last, output int lat);
    wait_rdy_a();
    a_data = d; a_dc = dc; a_last = last; a_vld = 1'b1;
    step();
    a_vld = 1'b0; a_data = ~d;
    check("accept_cs", 32'(a_csn), 32'd0);
    check("accept_dc", 32'(a_dco), 32'(dc));
    check("accept_rdy", 32'(a_rdy), 32'd0);
    check("accept_busy", 32'(a_busy), 32'd1);
    lat = 1;
    while (!a_rxv && lat < 400) begin step(); lat++; end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       dc;
    logic       loop;
    logic [7:0] slv;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int lat, n, r0, m0, a0, c0, bad, hi, tog_err;
    logic prev;
    logic [7:0] bd[3];
    logic       bdc[3];

    vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'h00, 8'hA5};
    vecs[1] = '{8'hFF, 1'b0, 1'b0, 8'h3C, 8'h3C};
    vecs[2] = '{8'h00, 1'b1, 1'b1, 8'h00, 8'h00};
    vecs[3] = '{8'h5A, 1'b0, 1'b0, 8'hC3, 8'hC3};
    vecs[4] = '{8'h81, 1'b1, 1'b0, 8'h7E, 8'h7E};

    rst_n = 1'b0;
    a_vld = 1'b0; a_data = 8'h00; a_dc = 1'b0; a_last = 1'b0;
    b_vld = 1'b0; b_data = 8'h00; b_dc = 1'b0; b_last = 1'b0;
    step(); step();
    check("rst_rdy", 32'(a_rdy), 32'd0);
    check("rst_rxv", 32'(a_rxv), 32'd0);
    check("rst_rxd", 32'(a_rxd), 32'h00);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_sclk", 32'(a_sclk), 32'd0);
    check("rst_mosi", 32'(a_mosi), 32'd0);
    check("rst_cs", 32'(a_csn), 32'd1);
    check("rst_dc", 32'(a_dco), 32'd0);
    check("rst_b_cs", 32'(b_csn), 32'd1);
    rst_n = 1'b1;

    // Single-byte frames at CLK_DIV = 2: rx at accept+35, CS rises 37 cycles after
    // the accept cycle (38 cycles counting it), byte_rdy_o back 2 cycles later
    for (int i = 0; i < 5; i++) begin
      loop_a = vecs[i].loop; slv_byte = vecs[i].slv;
      r0 = rxv_cnt; m0 = mosi0_cnt;
      send_a(vecs[i].data, vecs[i].dc, 1'b1, lat);
      check("vec_rx_latency", 32'(lat), 32'd35);
      check("vec_rx_data", 32'(a_rxd), 32'(vecs[i].exp_rx));
      check("vec_mosi_bits", 32'(mosi_cap), 32'(vecs[i].data));
      n = lat;
      while (!a_csn && n < 400) begin step(); n++; end
      check("vec_cs_rise_cyc", 32'(n), 32'd37);
      check("vec_gap_busy", 32'(a_busy), 32'd1);
      while (!a_rdy && n < 400) begin step(); n++; end
      check("vec_rdy_cyc", 32'(n), 32'd39);
      check("vec_idle_busy", 32'(a_busy), 32'd0);
      check("vec_rxv_pulses", 32'(rxv_cnt - r0), 32'd1);
      if (vecs[i].data == 8'hFF) check("vec_mosi_held_hi", 32'(mosi0_cnt - m0), 32'd0);
    end

    // Three-byte burst with byte_vld_i held high
    loop_a = 1'b1;
    bd[0] = 8'h01; bd[1] = 8'h12; bd[2] = 8'h34;
    bdc[0] = 1'b0; bdc[1] = 1'b1; bdc[2] = 1'b1;
    r0 = rxv_cnt; a0 = acc_cnt; c0 = csn_rise;
    for (int i = 0; i < 3; i++) begin
      wait_rdy_a();
      a_data = bd[i]; a_dc = bdc[i]; a_last = (i == 2); a_vld = 1'b1;
      step();
      check("burst_dc", 32'(a_dco), 32'(bdc[i]));
      check("burst_cs_low", 32'(a_csn), 32'd0);
    end
    a_vld = 1'b0;
    n = 0;
    while ((rxv_cnt - r0) < 3 && n < 400) begin step(); n++; end
    check("burst_rx_last", 32'(a_rxd), 32'h34);
    check("burst_cs_no_rise", 32'(csn_rise - c0), 32'd0);
    while (!a_rdy && n < 400) begin step(); n++; end
    check("burst_rxv_pulses", 32'(rxv_cnt - r0), 32'd3);
    check("burst_accepts", 32'(acc_cnt - a0), 32'd3);
    check("burst_cs_rises", 32'(csn_rise - c0), 32'd1);

    // Producer stalls in WAIT for 100 cycles
    send_a(8'h11, 1'b1, 1'b0, lat);
    check("stall_rx_latency", 32'(lat), 32'd35);
    check("stall_rx_data", 32'(a_rxd), 32'h11);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (a_csn || a_sclk || !a_rdy || !a_busy) bad++;
    end
    check("stall_wait_hold", 32'(bad), 32'd0);
    a_data = 8'h22; a_dc = 1'b0; a_last = 1'b1; a_vld = 1'b1;
    step();
    a_vld = 1'b0;
    check("stall_resume_dc", 32'(a_dco), 32'd0);
    n = 1; hi = 0;
    while (!a_sclk && n < 100) begin hi++; step(); n++; end
    check("stall_setup_len", 32'(hi), 32'd2);
    while (!a_rxv && n < 400) begin step(); n++; end
    check("stall_resume_latency", 32'(n), 32'd35);
    check("stall_resume_rx", 32'(a_rxd), 32'h22);
    while (!a_rdy && n < 400) begin step(); n++; end

    // Reset asserted mid-XFER after five SCLK rises
    r0 = rxv_cnt; n = rise_cnt;
    wait_rdy_a();
    a_data = 8'hF0; a_dc = 1'b1; a_last = 1'b1; a_vld = 1'b1;
    step();
    a_vld = 1'b0;
    bad = 0;
    while ((rise_cnt - n) < 5 && bad < 400) begin step(); bad++; end
    #2 rst_n = 1'b0;
    #1;
    check("abort_cs", 32'(a_csn), 32'd1);
    check("abort_sclk", 32'(a_sclk), 32'd0);
    check("abort_mosi", 32'(a_mosi), 32'd0);
    check("abort_dc", 32'(a_dco), 32'd0);
    check("abort_rxd", 32'(a_rxd), 32'h00);
    check("abort_busy", 32'(a_busy), 32'd0);
    check("abort_rdy", 32'(a_rdy), 32'd0);
    step(); step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) step();
    check("abort_no_rxv", 32'(rxv_cnt - r0), 32'd0);
    send_a(8'h3C, 1'b1, 1'b1, lat);
    check("abort_fresh_latency", 32'(lat), 32'd35);
    check("abort_fresh_rx", 32'(a_rxd), 32'h3C);

    // CLK_DIV = 1: SCLK toggles every cycle, rx at accept+18, 1-cycle HOLD and GAP
    n = 0;
    while (!b_rdy && n < 300) begin step(); n++; end
    check("b_rdy_wait", 32'(b_rdy), 32'd1);
    b_data = 8'h80; b_dc = 1'b1; b_last = 1'b1; b_vld = 1'b1;
    step();
    b_vld = 1'b0;
    check("b_accept_dc", 32'(b_dco), 32'd1);
    n = 1; hi = 0; tog_err = 0; prev = b_sclk;
    while (!b_rxv && n < 200) begin
      step(); n++;
      if (!b_rxv) begin
        if (b_sclk) hi++;
        if (n >= 3 && b_sclk == prev) tog_err++;
        prev = b_sclk;
      end
    end
    check("b_rx_latency", 32'(n), 32'd18);
    check("b_rx_data", 32'(b_rxd), 32'h80);
    check("b_sclk_high_halves", 32'(hi), 32'd8);
    check("b_sclk_toggle", 32'(tog_err), 32'd0);
    while (!b_csn && n < 200) begin step(); n++; end
    check("b_cs_rise_cyc", 32'(n), 32'd19);
    while (!b_rdy && n < 200) begin step(); n++; end
    check("b_rdy_cyc", 32'(n), 32'd20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
